sc_statemachine_lost_lives: RTL and testbench

// Game-control stage directly downstream of the two-player collision comparator.

---
 rtl/sc_statemachine_lost_lives_if.sv | 33 +++
 rtl/sc_statemachine_lost_lives.sv | 153 +++++++++++++++
 tb/tb_sc_statemachine_lost_lives.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sc_statemachine_lost_lives_if.sv
// Signal bundle between the player collision comparator / start button and the
// lives state machine; the state machine sits on the slave side.
interface sc_statemachine_lost_lives_if #(
    parameter int LIVESWIDTH = 2
);
    logic                  SC_STATEMACHINE_LOST_LIVES_start_InLow;
    logic                  SC_STATEMACHINE_LOST_LIVES_lost_InLow;
    logic [LIVESWIDTH-1:0] SC_STATEMACHINE_LOST_LIVES_lives_OutBUS;
    logic                  SC_STATEMACHINE_LOST_LIVES_playing_Out;
    logic                  SC_STATEMACHINE_LOST_LIVES_hit_Out;
    logic                  SC_STATEMACHINE_LOST_LIVES_gameover_Out;
    logic                  SC_STATEMACHINE_LOST_LIVES_load_Out;

    modport master (
        output SC_STATEMACHINE_LOST_LIVES_start_InLow,
        output SC_STATEMACHINE_LOST_LIVES_lost_InLow,
        input  SC_STATEMACHINE_LOST_LIVES_lives_OutBUS,
        input  SC_STATEMACHINE_LOST_LIVES_playing_Out,
        input  SC_STATEMACHINE_LOST_LIVES_hit_Out,
        input  SC_STATEMACHINE_LOST_LIVES_gameover_Out,
        input  SC_STATEMACHINE_LOST_LIVES_load_Out
    );

    modport slave (
        input  SC_STATEMACHINE_LOST_LIVES_start_InLow,
        input  SC_STATEMACHINE_LOST_LIVES_lost_InLow,
        output SC_STATEMACHINE_LOST_LIVES_lives_OutBUS,
        output SC_STATEMACHINE_LOST_LIVES_playing_Out,
        output SC_STATEMACHINE_LOST_LIVES_hit_Out,
        output SC_STATEMACHINE_LOST_LIVES_gameover_Out,
        output SC_STATEMACHINE_LOST_LIVES_load_Out
    );
endinterface

// File: rtl/sc_statemachine_lost_lives.sv
// Game-control FSM: turns the comparator's active-low collision flag into single
// hits, counts down lives, and drives playing/hit/game-over status plus a restart load pulse.
module sc_statemachine_lost_lives #(
    parameter int LIVESWIDTH      = 2,
    parameter int INIT_LIVES      = 3,
    parameter int HOLDWIDTH       = 8,
    parameter int HIT_HOLD_CYCLES = 16
) (
    input logic                          SC_STATEMACHINE_LOST_LIVES_CLOCK_50,
    input logic                          SC_STATEMACHINE_LOST_LIVES_RESET_InLow,
    sc_statemachine_lost_lives_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_HIT      = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    localparam logic [LIVESWIDTH-1:0] LIVES_INIT = LIVESWIDTH'(INIT_LIVES);
    localparam logic [LIVESWIDTH-1:0] LIVES_ONE  = LIVESWIDTH'(1);
    localparam logic [LIVESWIDTH-1:0] LIVES_ZERO = {LIVESWIDTH{1'b0}};
    localparam logic [HOLDWIDTH-1:0]  HOLD_INIT  = HOLDWIDTH'(HIT_HOLD_CYCLES - 1);
    localparam logic [HOLDWIDTH-1:0]  HOLD_ZERO  = {HOLDWIDTH{1'b0}};
    localparam logic [HOLDWIDTH-1:0]  HOLD_ONE   = HOLDWIDTH'(1);

    state_t                state_q,    state_d;
    logic [LIVESWIDTH-1:0] lives_q,    lives_d;
    logic [HOLDWIDTH-1:0]  hold_q,     hold_d;
    logic                  playing_q,  playing_d;
    logic                  hit_q,      hit_d;
    logic                  gameover_q, gameover_d;
    logic                  load_q,     load_d;

    // [0],[1] are the two synchroniser stages, [2] is the previous synchronised value
    logic [2:0]            start_sync_q;
    logic                  start_fall_s;
    logic                  lost_s;

    assign start_fall_s = start_sync_q[2] & ~start_sync_q[1];
    assign lost_s       = ~bus.SC_STATEMACHINE_LOST_LIVES_lost_InLow;

    // Start button synchroniser and falling-edge history
    always_ff @(posedge SC_STATEMACHINE_LOST_LIVES_CLOCK_50 or negedge SC_STATEMACHINE_LOST_LIVES_RESET_InLow) begin
        if (!SC_STATEMACHINE_LOST_LIVES_RESET_InLow) begin
            start_sync_q <= 3'b111;
        end else begin
            start_sync_q <= {start_sync_q[1:0], bus.SC_STATEMACHINE_LOST_LIVES_start_InLow};
        end
    end

    // State, lives, hold counter and registered status outputs
    always_ff @(posedge SC_STATEMACHINE_LOST_LIVES_CLOCK_50 or negedge SC_STATEMACHINE_LOST_LIVES_RESET_InLow) begin
        if (!SC_STATEMACHINE_LOST_LIVES_RESET_InLow) begin
            state_q    <= ST_IDLE;
            lives_q    <= LIVES_ZERO;
            hold_q     <= HOLD_ZERO;
            playing_q  <= 1'b0;
            hit_q      <= 1'b0;
            gameover_q <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            hold_q     <= hold_d;
            playing_q  <= playing_d;
            hit_q      <= hit_d;
            gameover_q <= gameover_d;
            load_q     <= load_d;
        end
    end

    // Next-state logic; status outputs are decoded from the next state so they
    // line up with the state register
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        hold_d  = hold_q;
        load_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_fall_s) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_INIT;
                    hold_d  = HOLD_ZERO;
                    load_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_PLAY: begin
                if (lost_s) begin
                    if (lives_q > LIVES_ONE) begin
                        lives_d = lives_q - LIVES_ONE;
                        hold_d  = HOLD_INIT;
                        state_d = ST_HIT;
                    end else begin
                        // last life (or none left): saturate at zero
                        lives_d = LIVES_ZERO;
                        state_d = ST_GAMEOVER;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end

            ST_HIT: begin
                if (hold_q != HOLD_ZERO) begin
                    hold_d  = hold_q - HOLD_ONE;
                    state_d = ST_HIT;
                end else if (!lost_s) begin
                    state_d = ST_PLAY;
                end else begin
                    // still overlapping: wait for separation so one overlap costs one life
                    state_d = ST_HIT;
                end
            end

            ST_GAMEOVER: begin
                lives_d = LIVES_ZERO;
                if (start_fall_s) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_INIT;
                    hold_d  = HOLD_ZERO;
                    load_d  = 1'b1;
                end else begin
                    state_d = ST_GAMEOVER;
                end
            end

            default: begin
                state_d = ST_IDLE;
                lives_d = LIVES_ZERO;
                hold_d  = HOLD_ZERO;
                load_d  = 1'b0;
            end
        endcase

        playing_d  = (state_d == ST_PLAY) || (state_d == ST_HIT);
        hit_d      = (state_d == ST_HIT);
        gameover_d = (state_d == ST_GAMEOVER);
    end

    assign bus.SC_STATEMACHINE_LOST_LIVES_lives_OutBUS = lives_q;
    assign bus.SC_STATEMACHINE_LOST_LIVES_playing_Out  = playing_q;
    assign bus.SC_STATEMACHINE_LOST_LIVES_hit_Out      = hit_q;
    assign bus.SC_STATEMACHINE_LOST_LIVES_gameover_Out = gameover_q;
    assign bus.SC_STATEMACHINE_LOST_LIVES_load_Out     = load_q;

endmodule

// File: tb/tb_sc_statemachine_lost_lives.sv
// Directed bench for the lives state machine: inputs change and outputs are
// sampled on the falling clock edge, expected values are hand-derived.
module tb_sc_statemachine_lost_lives;

    logic clk_s;
    logic rst_n_s;
    int   checks_cnt_r;
    int   errors_cnt_r;
    int   load_cnt_r;
    int   load_pos_r;
    int   hit_cnt_r;

    sc_statemachine_lost_lives_if #(.LIVESWIDTH(2)) bus_if ();

    sc_statemachine_lost_lives #(
        .LIVESWIDTH      (2),
        .INIT_LIVES      (3),
        .HOLDWIDTH       (8),
        .HIT_HOLD_CYCLES (16)
    ) u_dut (
        .SC_STATEMACHINE_LOST_LIVES_CLOCK_50    (clk_s),
        .SC_STATEMACHINE_LOST_LIVES_RESET_InLow (rst_n_s),
        .bus                                    (bus_if)
    );

    // 50 MHz-style free-running clock
    initial begin
        clk_s = 1'b0;
        forever #10 clk_s = ~clk_s;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt_r++;
        if (obs !== exp) begin
            errors_cnt_r++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int lives, input int playing,
                              input int hit, input int gameover, input int load);
        check_eq({tag, " lives"},    32'(bus_if.SC_STATEMACHINE_LOST_LIVES_lives_OutBUS), 32'(lives));
        check_eq({tag, " playing"},  32'(bus_if.SC_STATEMACHINE_LOST_LIVES_playing_Out),  32'(playing));
        check_eq({tag, " hit"},      32'(bus_if.SC_STATEMACHINE_LOST_LIVES_hit_Out),      32'(hit));
        check_eq({tag, " gameover"}, 32'(bus_if.SC_STATEMACHINE_LOST_LIVES_gameover_Out), 32'(gameover));
        check_eq({tag, " load"},     32'(bus_if.SC_STATEMACHINE_LOST_LIVES_load_Out),     32'(load));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_s);
    endtask

    // One-cycle collision; returns at the falling edge after the sampling edge
    task automatic collide();
        bus_if.SC_STATEMACHINE_LOST_LIVES_lost_InLow = 1'b0;
        @(negedge clk_s);
        bus_if.SC_STATEMACHINE_LOST_LIVES_lost_InLow = 1'b1;
    endtask

    // Press start briefly and check the load pulse lands two edges after the first low sample
    task automatic press_start(input string tag);
        bus_if.SC_STATEMACHINE_LOST_LIVES_start_InLow = 1'b0;
        cycles(3);
        check_outs(tag, 3, 1, 0, 0, 1);
        bus_if.SC_STATEMACHINE_LOST_LIVES_start_InLow = 1'b1;
        @(negedge clk_s);
        check_eq({tag, " load drop"}, 32'(bus_if.SC_STATEMACHINE_LOST_LIVES_load_Out), 32'd0);
        cycles(3);
    endtask

    initial begin
        checks_cnt_r = 0;
        errors_cnt_r = 0;
        rst_n_s = 1'b0;
        bus_if.SC_STATEMACHINE_LOST_LIVES_start_InLow = 1'b1;
        bus_if.SC_STATEMACHINE_LOST_LIVES_lost_InLow  = 1'b1;

        // 1: reset, then lost is ignored in IDLE
        cycles(3);
        check_outs("rst", 0, 0, 0, 0, 0);
        rst_n_s = 1'b1;
        cycles(2);
        check_outs("idle", 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus_if.SC_STATEMACHINE_LOST_LIVES_lost_InLow = i[0];
            @(negedge clk_s);
        end
        bus_if.SC_STATEMACHINE_LOST_LIVES_lost_InLow = 1'b1;
        check_outs("idle lost", 0, 0, 0, 0, 0);

        // 2: start held 10 cycles gives one load pulse at index 2
        load_cnt_r = 0;
        load_pos_r = -1;
        bus_if.SC_STATEMACHINE_LOST_LIVES_start_InLow = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_s);
            if (bus_if.SC_STATEMACHINE_LOST_LIVES_load_Out) begin
                load_cnt_r++;
                if (load_pos_r < 0) load_pos_r = i;
            end
            if (i == 9) bus_if.SC_STATEMACHINE_LOST_LIVES_start_InLow = 1'b1;
        end
        check_eq("load count", 32'(load_cnt_r), 32'd1);
        check_eq("load pos", 32'(load_pos_r), 32'd2);
        check_outs("play", 3, 1, 0, 0, 0);

        // 3: single-cycle collision -> 16 cycles of HIT
        collide();
        check_outs("hit1", 2, 1, 1, 0, 0);
        hit_cnt_r = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_s);
            if (bus_if.SC_STATEMACHINE_LOST_LIVES_hit_Out) hit_cnt_r++;
        end
        check_eq("hit len", 32'(hit_cnt_r), 32'd16);
        check_outs("after hit1", 2, 1, 0, 0, 0);

        // 4: long overlap costs one life and HIT lasts until release
        bus_if.SC_STATEMACHINE_LOST_LIVES_lost_InLow = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_s);
            if (i == 50) check_outs("long mid", 1, 1, 1, 0, 0);
        end
        check_outs("long end", 1, 1, 1, 0, 0);
        bus_if.SC_STATEMACHINE_LOST_LIVES_lost_InLow = 1'b1;
        @(negedge clk_s);
        check_outs("long release", 1, 1, 0, 0, 0);

        // last life -> GAMEOVER, no wrap, start restarts at 3
        collide();
        check_outs("go", 0, 0, 0, 1, 0);
        collide();
        cycles(1);
        check_outs("go hold", 0, 0, 0, 1, 0);
        press_start("restart1");

        // 5: three separated collisions 2,1,0
        collide();
        check_outs("c1", 2, 1, 1, 0, 0);
        cycles(20);
        check_outs("c1 done", 2, 1, 0, 0, 0);
        collide();
        check_outs("c2", 1, 1, 1, 0, 0);
        cycles(20);
        collide();
        check_outs("c3", 0, 0, 0, 1, 0);
        press_start("restart2");

        // 6: asynchronous reset while hold == 7 in HIT
        collide();
        cycles(8);
        check_outs("pre rst", 2, 1, 1, 0, 0);
        #3 rst_n_s = 1'b0;
        #1 check_outs("async rst", 0, 0, 0, 0, 0);
        @(negedge clk_s);
        rst_n_s = 1'b1;
        bus_if.SC_STATEMACHINE_LOST_LIVES_lost_InLow = 1'b0;
        cycles(3);
        bus_if.SC_STATEMACHINE_LOST_LIVES_lost_InLow = 1'b1;
        check_outs("post rst", 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt_r, errors_cnt_r);
        $finish;
    end

endmodule
